// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchronizer chain plus debounce filter,
// producing a registered clean level and one-cycle rise/fall pulses.
module input_conditioner #(
   parameter int WIDTH           = 4,
   parameter int STAGES          = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] value_i,
   output logic [WIDTH-1:0] value_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   genvar c;
   for (c = 0; c < WIDTH; c++) begin : g_ch
      logic [STAGES-1:0] sync;
      logic [CW-1:0]     cnt;
      logic              val, rise, fall, s;
      assign s = sync[STAGES-1];
      always_ff @(posedge clock_i or posedge reset_i)
         if (reset_i) begin
            sync <= '0;
            cnt  <= '0;
            val  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
         end else begin
            sync <= {sync[STAGES-2:0], value_i[c]};
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == val) cnt <= '0;
            else if (cnt == LAST) begin
               // new level has persisted long enough: accept it and pulse
               val  <= s;
               cnt  <= '0;
               rise <= s;
               fall <= ~s;
            end else cnt <= cnt + 1'b1;
         end
      assign value_o[c] = val;
      assign rise_o[c]  = rise;
      assign fall_o[c]  = fall;
   end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed stimulus with a cycle-stamped expectation
// scoreboard drained by an independent monitor.
module tb_input_conditioner;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] vi  = '0;
   logic [3:0] vo, ro, fo;
   logic       vi2 = 1'b0;
   logic       vo2, ro2, fo2;
   int         cyc;
   int         n_chk = 0;
   int         n_fail = 0;

   typedef struct {
      int         at;
      bit         d;
      logic [3:0] m, v, r, f;
   } exp_t;
   exp_t sb[$];

   input_conditioner dut (
      .clock_i(clk), .reset_i(rst), .value_i(vi),
      .value_o(vo), .rise_o(ro), .fall_o(fo)
   );

   input_conditioner #(.WIDTH(1), .STAGES(3), .DEBOUNCE_CYCLES(1)) dut2 (
      .clock_i(clk), .reset_i(rst), .value_i(vi2),
      .value_o(vo2), .rise_o(ro2), .fall_o(fo2)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst)
      if (rst) cyc <= 0;
      else cyc <= cyc + 1;

   function automatic void check(string name, logic [3:0] got, logic [3:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, got, want);
      end
   endfunction

   function automatic void push(int at, bit d, logic [3:0] m, logic [3:0] v, logic [3:0] r, logic [3:0] f);
      exp_t e;
      e.at = at; e.d = d; e.m = m; e.v = v; e.r = r; e.f = f;
      sb.push_back(e);
   endfunction

   task automatic at(int n);
      while (cyc != n) @(negedge clk);
   endtask

   // monitor: compares every expectation stamped for the current edge count
   always @(negedge clk) begin
      if (!rst)
         for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].at <= cyc) begin
               logic [3:0] gv, gr, gf;
               gv = sb[i].d ? {3'b0, vo2} : vo;
               gr = sb[i].d ? {3'b0, ro2} : ro;
               gf = sb[i].d ? {3'b0, fo2} : fo;
               if (sb[i].at < cyc) check($sformatf("stale_d%0d@%0d", sb[i].d, sb[i].at), 4'h1, 4'h0);
               check($sformatf("value_d%0d@%0d", sb[i].d, cyc), gv & sb[i].m, sb[i].v & sb[i].m);
               check($sformatf("rise_d%0d@%0d", sb[i].d, cyc), gr & sb[i].m, sb[i].r & sb[i].m);
               check($sformatf("fall_d%0d@%0d", sb[i].d, cyc), gf & sb[i].m, sb[i].f & sb[i].m);
               sb.delete(i);
            end
   end

   initial begin
      #3 rst = 1'b1;
      #1;
      check("reset_value", vo, 4'b0);
      check("reset_rise", ro, 4'b0);
      check("reset_fall", fo, 4'b0);
      check("reset_d2", {1'b0, vo2, ro2, fo2}, 4'b0);
      @(negedge clk) rst = 1'b0;
      // phase 1: clean edge on channel 0 (input changes before edge 10)
      for (int c = 1; c <= 5; c++) push(c, 1'b1, 4'b0001, 4'b0, 4'b0, 4'b0);
      for (int c = 10; c <= 26; c++) push(c, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      push(27, 1'b0, 4'b1111, 4'b0001, 4'b0001, 4'b0000);
      for (int c = 28; c <= 47; c++) push(c, 1'b0, 4'b1111, 4'b0001, 4'b0000, 4'b0000);
      at(9);  vi[0] = 1'b1;
      at(40); vi[0] = 1'b0;
      // channel 0 is now mid-count (cnt = 5) toward 0; reset must clear immediately
      at(47);
      #2 rst = 1'b1;
      #1;
      check("midcount_reset_value", vo, 4'b0);
      check("midcount_reset_rise", ro, 4'b0);
      check("midcount_reset_fall", fo, 4'b0);
      @(negedge clk) rst = 1'b0;
      // phase 2: expectations relative to the new reset release
      for (int c = 5; c <= 47; c++) push(c, 1'b0, 4'b0010, 4'b0, 4'b0, 4'b0);
      push(48, 1'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
      push(49, 1'b0, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
      push(117, 1'b0, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
      push(118, 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
      push(119, 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
      for (int c = 61; c <= 140; c++) push(c, 1'b0, 4'b0100, 4'b0, 4'b0, 4'b0);
      push(167, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      push(168, 1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b0000);
      push(169, 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
      push(197, 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
      push(198, 1'b0, 4'b1111, 4'b0111, 4'b0000, 4'b1000);
      push(199, 1'b0, 4'b1111, 4'b0111, 4'b0000, 4'b0000);
      push(12, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      push(13, 1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
      push(14, 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      push(15, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      push(16, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      at(4);  vi[1] = 1'b1;
      at(9);  vi2 = 1'b1;
      at(11); vi2 = 1'b0;
      at(19); vi[1] = 1'b0;
      at(30); vi[1] = 1'b1;
      for (int c = 60; c < 120; c++) begin
         at(c);
         vi[2] = (((c - 60) / 3) % 2) == 0;
         if (c == 100) vi[1] = 1'b0;
      end
      at(120); vi[2] = 1'b0;
      at(150); vi = 4'b1111;
      at(180); vi = 4'b0111;
      for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) check("scoreboard_drain", 4'(sb.size()), 4'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
